// File: rtl/bpf_fwd_pkg.sv
// Shared types and constants for the BPF packet forwarder.
// The FORWARDER_STATS_EN build option is implemented in bpf_forwarder.sv.
package bpf_fwd_pkg;

    localparam int FWD_SKID_DEPTH = 2;
    localparam int FWD_PLEN_EXTRA = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE,
        S_HOLD
    } fwd_state_e;

    // A length of 2^AW words needs one bit more than the address.
    function automatic int fwd_plen_width(input int aw);
        return aw + FWD_PLEN_EXTRA;
    endfunction

endpackage

// File: rtl/bpf_forwarder_if.sv
// AXI4-Stream bundle carrying forwarded packet words.
// The master drives data/valid/last and the slave drives ready.
interface bpf_forwarder_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/fwd_skid_fifo.sv
// Two-entry registered FIFO holding returned read words plus a last flag.
// Entry 0 is always the head so the output is driven straight from a flop.
module fwd_skid_fifo
    import bpf_fwd_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    localparam int W          = DATA_WIDTH + 1,
    localparam int OW         = $clog2(FWD_SKID_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [OW-1:0] occ_o,
    output logic [W-1:0]  head_o,
    output logic          valid_o
);

    logic [W-1:0]  e0_q;
    logic [W-1:0]  e1_q;
    logic [OW-1:0] occ_q;

    assign occ_o   = occ_q;
    assign head_o  = e0_q;
    assign valid_o = (occ_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == '0) e0_q <= din_i;
                    else             e1_q <= din_i;
                    occ_q <= occ_q + OW'(1);
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    occ_q <= occ_q - OW'(1);
                end
                2'b11: begin
                    if (occ_q == OW'(1)) begin
                        e0_q <= din_i;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bpf_forwarder.sv
// Streams an accepted packet out of packet memory as AXI4-Stream, then releases it.
// Define FORWARDER_STATS_EN to add packet and word counters.
module bpf_forwarder
    import bpf_fwd_pkg::*;
#(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH           = 64,
    parameter int PLEN_WIDTH           = fwd_plen_width(SNOOP_FWD_ADDR_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
    input  logic [DATA_WIDTH-1:0]           forwarder_rd_data,
    output logic                            forwarder_rd_en,
    output logic                            forwarder_done,
    input  logic                            ready_for_forwarder,
    input  logic [PLEN_WIDTH-1:0]           len_to_forwarder,
    bpf_forwarder_if.master                 m_axis
`ifdef FORWARDER_STATS_EN
    ,
    output logic [31:0]                     pkt_count,
    output logic [31:0]                     word_count
`endif
);

    localparam int AW = SNOOP_FWD_ADDR_WIDTH;
    localparam int PW = PLEN_WIDTH;
    localparam logic [PW-1:0] DEPTH = PW'(2 ** AW);

    fwd_state_e    state_q;
    logic [PW-1:0] len_q;
    logic [PW-1:0] rd_cnt_q;
    logic [PW-1:0] tx_cnt_q;
    logic [AW-1:0] addr_q;
    logic          inflight_q;
    logic          last_q;

    logic [1:0]        occ;
    logic [DATA_WIDTH:0] head;
    logic              head_vld;
    logic              pop;
    logic              space;
    logic [2:0]        lvl;
    logic [PW-1:0]     len_clip;

    fwd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({last_q, forwarder_rd_data}),
        .pop_i   (pop),
        .occ_o   (occ),
        .head_o  (head),
        .valid_o (head_vld)
    );

    assign m_axis.tvalid = head_vld;
    assign m_axis.tdata  = head[DATA_WIDTH-1:0];
    assign m_axis.tlast  = head_vld & head[DATA_WIDTH];

    assign pop      = head_vld & m_axis.tready;
    assign len_clip = (len_to_forwarder > DEPTH) ? DEPTH : len_to_forwarder;

    // Words held or in flight after this cycle's pop must fit the skid buffer.
    assign lvl   = {1'b0, occ} + {2'b0, inflight_q};
    assign space = lvl < (3'(FWD_SKID_DEPTH) + {2'b0, pop});

    assign forwarder_rd_en = (state_q == S_STREAM)
                           && (rd_cnt_q != len_q) && space;
    assign forwarder_rd_addr = forwarder_rd_en ? rd_cnt_q[AW-1:0] : addr_q;
    assign forwarder_done    = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            inflight_q <= forwarder_rd_en;
            last_q     <= forwarder_rd_en && (rd_cnt_q == len_q - PW'(1));
            addr_q     <= forwarder_rd_addr;
            if (pop) tx_cnt_q <= tx_cnt_q + PW'(1);
            unique case (state_q)
                S_IDLE: begin
                    if (ready_for_forwarder) begin
                        len_q    <= len_clip;
                        rd_cnt_q <= '0;
                        tx_cnt_q <= '0;
                        state_q  <= (len_clip == '0) ? S_DONE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (forwarder_rd_en) begin
                        rd_cnt_q <= rd_cnt_q + PW'(1);
                        if (rd_cnt_q + PW'(1) == len_q) state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (pop && (tx_cnt_q == len_q - PW'(1))) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_HOLD;
                S_HOLD:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FORWARDER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count  <= '0;
            word_count <= '0;
        end else begin
            if (forwarder_done) pkt_count  <= pkt_count + 32'd1;
            if (pop)            word_count <= word_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bpf_forwarder.sv
// Self-checking bench for bpf_forwarder: directed and random packets
// compared against a memory-image model of the expected stream.
module tb_bpf_forwarder;

    localparam int AW = 9;
    localparam int DW = 64;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en;
    logic          done;
    logic          rdy;
    logic [PW-1:0] ln;

    bpf_forwarder_if #(.DATA_WIDTH(DW)) axis ();

`ifdef FORWARDER_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] word_count;
`endif

    bpf_forwarder #(
        .SNOOP_FWD_ADDR_WIDTH (AW),
        .DATA_WIDTH           (DW),
        .PLEN_WIDTH           (PW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_data   (rd_data),
        .forwarder_rd_en     (rd_en),
        .forwarder_done      (done),
        .ready_for_forwarder (rdy),
        .len_to_forwarder    (ln),
        .m_axis              (axis)
`ifdef FORWARDER_STATS_EN
        ,
        .pkt_count           (pkt_count),
        .word_count          (word_count)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [512];

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: tready always 1, 1: pattern 1,0,0,1, 2: random
    task automatic run_pkt(input int l, input int mode, input bit seq);
        logic [63:0] got[$];
        int lastpos[$];
        logic [3:0] pat;
        logic [DW-1:0] prev_data;
        logic prev_last, prev_stall;
        int n, cyc, budget, done_cyc, first_rd, first_v, last_hs;
        int reads, pops, stall_err, ahead_err, addr_err, done_cnt;
        pat = 4'b1001;
        n = (l > 512) ? 512 : l;
        for (int i = 0; i < 512; i++)
            mem[i] = seq ? 64'hA0 + 64'(i) : {$urandom, $urandom};
        cyc = 0; done_cyc = -1; first_rd = -1; first_v = -1; last_hs = -1;
        reads = 0; pops = 0; stall_err = 0; ahead_err = 0; addr_err = 0;
        done_cnt = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        budget = n * 8 + 40;
        @(negedge clk);
        rdy = 1'b1;
        ln  = PW'(l);
        axis.tready = 1'b0;
        @(posedge clk);
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done_cyc >= 0) rdy = 1'b0;
            unique case (mode)
                0:       axis.tready = 1'b1;
                1:       axis.tready = pat[(cyc - 1) % 4];
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall && (!axis.tvalid || axis.tdata !== prev_data
                               || axis.tlast !== prev_last))
                stall_err++;
            if (rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (int'(rd_addr) != reads) addr_err++;
                reads++;
            end
            if (axis.tvalid && first_v < 0) first_v = cyc;
            if (axis.tvalid && axis.tready) begin
                got.push_back(axis.tdata);
                if (axis.tlast) lastpos.push_back(pops);
                pops++;
                last_hs = cyc;
            end
            if (reads - pops > 2) ahead_err++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_last  = axis.tlast;
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
        end
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("done_cnt", 64'(done_cnt), 64'd1);
        chk("words", 64'(got.size()), 64'(n));
        for (int i = 0; i < got.size() && i < n; i++)
            chk("data", got[i], mem[i]);
        chk("tlast_cnt", 64'(lastpos.size()), 64'(n > 0));
        if (lastpos.size() == 1) chk("tlast_pos", 64'(lastpos[0]), 64'(n - 1));
        chk("reads", 64'(reads), 64'(n));
        chk("addr_seq", 64'(addr_err), 64'd0);
        chk("stall_stable", 64'(stall_err), 64'd0);
        chk("reads_ahead", 64'(ahead_err), 64'd0);
        if (n == 0) begin
            chk("zero_done_lat", 64'(done_cyc), 64'd1);
            chk("zero_no_valid", 64'(first_v), 64'(-1));
        end else begin
            chk("first_rd", 64'(first_rd), 64'd1);
            chk("first_valid", 64'(first_v), 64'd3);
            chk("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
            if (mode == 0) chk("done_lat", 64'(done_cyc), 64'(n + 3));
        end
    endtask

    initial begin
        int dcnt;
        rst = 1'b0;
        rdy = 1'b0;
        ln  = '0;
        axis.tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tlast", 64'(axis.tlast), 64'd0);
        chk("rst_tdata", axis.tdata, 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_pkt(4, 0, 1'b1);
        run_pkt(0, 0, 1'b0);
        run_pkt(8, 1, 1'b0);
        run_pkt(512, 0, 1'b0);

        // Reset asserted while the 3rd word of a 10-word packet is on the bus.
        for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
        @(negedge clk);
        rdy = 1'b1;
        ln  = PW'(10);
        axis.tready = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        #1;
        chk("pre_rst_valid", 64'(axis.tvalid), 64'd1);
        chk("pre_rst_data", axis.tdata, mem[2]);
        rst = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(axis.tlast), 64'd0);
        chk("mid_rst_tdata", axis.tdata, 64'd0);
        chk("mid_rst_rd_en", 64'(rd_en), 64'd0);
        chk("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        rdy  = 1'b0;
        dcnt = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("mid_rst_no_done", 64'(dcnt), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        run_pkt(2, 0, 1'b0);

        for (int k = 0; k < 6; k++)
            run_pkt($urandom_range(1, 40), $urandom_range(0, 2), 1'b0);
        run_pkt(700, 2, 1'b0);

`ifdef FORWARDER_STATS_EN
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_pkt(3, 0, 1'b0);
        run_pkt(0, 0, 1'b0);
        run_pkt(5, 2, 1'b0);
        @(negedge clk);
        #1;
        chk("pkt_count", 64'(pkt_count), 64'd3);
        chk("word_count", 64'(word_count), 64'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bpf_forwarder.md
Name: bpf_forwarder

Overview:
- Reader at the far end of the packet memory's forwarder port.
- When a filtered (accepted) packet is ready, reads it word by word from packet memory and emits it as an AXI4-Stream master with TLAST on the final word.
- Pulses done to release the buffer back to the snooper/CPU ping-pong.
- Sits between the BPF VM and the downstream egress logic.

Parameters:
- SNOOP_FWD_ADDR_WIDTH, 9: word address width of the forwarder read port; buffer depth is 2^SNOOP_FWD_ADDR_WIDTH words.
- DATA_WIDTH, 64: forwarder read data width and TDATA width.
- PLEN_WIDTH, 10: packet length width in words; must equal SNOOP_FWD_ADDR_WIDTH+1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- forwarder_rd_addr  out  SNOOP_FWD_ADDR_WIDTH  word read address.
- forwarder_rd_data  in  DATA_WIDTH  read data, valid one cycle after forwarder_rd_en.
- forwarder_rd_en  out  1  read strobe.
- forwarder_done  out  1  one-cycle pulse; packet fully sent.
- ready_for_forwarder  in  1  a packet is available; held high until done.
- len_to_forwarder  in  PLEN_WIDTH  packet length in words; valid while ready_for_forwarder is high.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  final word of packet.

Behaviour:
- Reset values (asynchronous, rst=0): all outputs 0; state IDLE; counters 0; buffer empty. Reset mid-packet aborts immediately: no done pulse, no TLAST.
- States: IDLE, STREAM, FLUSH, DONE, HOLD.
- IDLE: on ready_for_forwarder=1, latch len_q = min(len_to_forwarder, 2^SNOOP_FWD_ADDR_WIDTH).
  - If len_q=0, go to DONE.
  - Otherwise go to STREAM with rd_cnt=0 and tx_cnt=0.
- STREAM:
  - Issue forwarder_rd_en with forwarder_rd_addr=rd_cnt when occ + inflight - pop < 2, where occ is skid-buffer occupancy (0..2), inflight is a read issued last cycle, and pop means TVALID&TREADY this cycle. Increment rd_cnt on each read.
  - When rd_cnt reaches len_q, go to FLUSH.
  - forwarder_rd_addr holds its last value when not reading.
- Read data return: forwarder_rd_data is captured into a 2-entry skid FIFO in the cycle after the read. The FIFO head drives TDATA/TVALID.
- Latency: read issued at cycle T gives TVALID at T+2. ready_for_forwarder sampled at cycle 0 gives first rd_en at 1 and first TVALID at 3.
- Throughput: one word per cycle sustained while TREADY=1.
- AXI rules:
  - TDATA and TLAST are stable while TVALID=1 and TREADY=0.
  - TVALID never drops without a handshake.
  - TLAST=1 exactly on the word with tx_cnt = len_q-1.
- FLUSH: wait until the TLAST handshake, then go to DONE.
- DONE: assert forwarder_done for exactly one cycle, then go to HOLD.
- HOLD: one cycle, ignoring ready_for_forwarder (the packet memory drops ready one cycle after done), then go to IDLE.
- Back-to-back packets: the next packet is sampled no earlier than 2 cycles after the done pulse.
- Width rules: rd_cnt and tx_cnt are PLEN_WIDTH bits. The address is rd_cnt[SNOOP_FWD_ADDR_WIDTH-1:0]. A full-depth packet (len=512) reads addresses 0..511 with no wrap beyond.
- ready_for_forwarder dropping mid-packet is a protocol violation; the block ignores it and completes the packet.

Optional Feature:
- Macro FORWARDER_STATS_EN.
- When defined: adds output pkt_count (32 bits) and output word_count (32 bits).
  - pkt_count increments on each done pulse, including zero-length packets.
  - word_count increments on each TVALID&TREADY handshake.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bpf_fwd_pkg holds:
  - the state enum (IDLE, STREAM, FLUSH, DONE, HOLD);
  - the PLEN_WIDTH derivation constant;
  - the skid depth constant of 2.
- One sub-module, fwd_skid_fifo: a 2-entry registered FIFO with push/pop, occupancy output and head data/last. It is parameterised on DATA_WIDTH plus 1 bit for last.

Test Plan:
- len=4 with words 0xA0..0xA3, TREADY=1: TVALID on cycles 3..6, data A0,A1,A2,A3, TLAST only on A3, done pulse for one cycle after the A3 handshake, rd_addr 0..3.
- len=0: no rd_en, no TVALID, done pulses 1 cycle after ready is sampled, then returns to IDLE.
- len=8 with TREADY toggling 1,0,0,1 repeating: TDATA stable during stalls, never more than 2 reads ahead of output, all 8 words in order, exactly one TLAST.
- len=512 (full depth), TREADY=1: 512 consecutive handshakes, addresses 0..511, no wrap, TLAST on word 511.
- Assert rst low on the 3rd word of a len=10 packet: all outputs go to 0 at once, no done. After release, a new len=2 packet streams correctly.
- With FORWARDER_STATS_EN: three packets of lengths 3, 0 and 5 give pkt_count=3 and word_count=8.
